read_arbiter: RTL

// - Upstream of read_fsm: buffers AR requests from masters M0/M1 (one entry each), grants one round-robin.
// - Presents the grant to read_fsm as ARVALID_Mx (held for the whole transaction) plus ARVALID_Mx_IN (address valid).
// - Never asserts both grant levels at once. Releases the grant after the last R beat of the granted master.

---
 rtl/read_arbiter_pkg.sv | 34 +++
 rtl/read_arbiter_if.sv | 59 +++++
 rtl/read_arbiter_ar_req_buf.sv | 46 ++++
 rtl/read_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/read_arbiter_pkg.sv
// Shared widths, AR request record, FSM state encoding and reset payload for read_arbiter.
package read_arbiter_pkg;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 4;
  localparam int SIZE_W = 3;

  localparam logic [1:0]        BURST_INCR = 2'd1;
  localparam logic [SIZE_W-1:0] SIZE_WORD  = 3'd2;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
    logic [1:0]        burst;
  } ar_req_t;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ST_IDLE = 2'd0;
  localparam arb_state_t ST_ADDR = 2'd1;
  localparam arb_state_t ST_DATA = 2'd2;

  // Payload presented on an ungranted port: zeros except word size and INCR burst.
  function automatic ar_req_t ar_req_idle();
    ar_req_t r;
    r       = '0;
    r.size  = SIZE_WORD;
    r.burst = BURST_INCR;
    return r;
  endfunction

endpackage

// File: rtl/read_arbiter_if.sv
// Bus bundle around read_arbiter: master-side AR requests, read_fsm-facing AR grant, R monitor.
// Handshakes: a master AR transfer happens on a rising clk edge where MREQ_ARVALID_Mx and
// MREQ_ARREADY_Mx are both 1; an address transfer where ARVALID_Mx_IN and ARREADY_Mx are both 1;
// an R beat where RVALID_Mx and RREADY_Mx are both 1. Valid never depends on ready.
// Modport master is the arbiter's view, slave is the surrounding environment.
interface read_arbiter_if;
  import read_arbiter_pkg::*;

  logic [ID_W-1:0]   MREQ_ARID_M0,    MREQ_ARID_M1;
  logic [ADDR_W-1:0] MREQ_ARADDR_M0,  MREQ_ARADDR_M1;
  logic [LEN_W-1:0]  MREQ_ARLEN_M0,   MREQ_ARLEN_M1;
  logic [SIZE_W-1:0] MREQ_ARSIZE_M0,  MREQ_ARSIZE_M1;
  logic [1:0]        MREQ_ARBURST_M0, MREQ_ARBURST_M1;
  logic              MREQ_ARVALID_M0, MREQ_ARVALID_M1;
  logic              MREQ_ARREADY_M0, MREQ_ARREADY_M1;

  logic [ID_W-1:0]   ARID_M0,    ARID_M1;
  logic [ADDR_W-1:0] ARADDR_M0,  ARADDR_M1;
  logic [LEN_W-1:0]  ARLEN_M0,   ARLEN_M1;
  logic [SIZE_W-1:0] ARSIZE_M0,  ARSIZE_M1;
  logic [1:0]        ARBURST_M0, ARBURST_M1;
  logic              ARVALID_M0, ARVALID_M1;
  logic              ARVALID_M0_IN, ARVALID_M1_IN;
  logic              ARREADY_M0, ARREADY_M1;

  logic              RVALID_M0, RVALID_M1;
  logic              RREADY_M0, RREADY_M1;
  logic              RLAST_M0,  RLAST_M1;

  arb_state_t        dbg_state;
  logic [LEN_W:0]    dbg_beat_cnt;

  modport master (
    input  MREQ_ARID_M0, MREQ_ARID_M1, MREQ_ARADDR_M0, MREQ_ARADDR_M1,
           MREQ_ARLEN_M0, MREQ_ARLEN_M1, MREQ_ARSIZE_M0, MREQ_ARSIZE_M1,
           MREQ_ARBURST_M0, MREQ_ARBURST_M1, MREQ_ARVALID_M0, MREQ_ARVALID_M1,
    output MREQ_ARREADY_M0, MREQ_ARREADY_M1,
    output ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
           ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1,
           ARVALID_M0, ARVALID_M1, ARVALID_M0_IN, ARVALID_M1_IN,
    input  ARREADY_M0, ARREADY_M1,
    input  RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1, RLAST_M0, RLAST_M1,
    output dbg_state, dbg_beat_cnt
  );

  modport slave (
    output MREQ_ARID_M0, MREQ_ARID_M1, MREQ_ARADDR_M0, MREQ_ARADDR_M1,
           MREQ_ARLEN_M0, MREQ_ARLEN_M1, MREQ_ARSIZE_M0, MREQ_ARSIZE_M1,
           MREQ_ARBURST_M0, MREQ_ARBURST_M1, MREQ_ARVALID_M0, MREQ_ARVALID_M1,
    input  MREQ_ARREADY_M0, MREQ_ARREADY_M1,
    input  ARID_M0, ARID_M1, ARADDR_M0, ARADDR_M1, ARLEN_M0, ARLEN_M1,
           ARSIZE_M0, ARSIZE_M1, ARBURST_M0, ARBURST_M1,
           ARVALID_M0, ARVALID_M1, ARVALID_M0_IN, ARVALID_M1_IN,
    output ARREADY_M0, ARREADY_M1,
    output RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1, RLAST_M0, RLAST_M1,
    input  dbg_state, dbg_beat_cnt
  );

endinterface

// File: rtl/read_arbiter_ar_req_buf.sv
// Single-entry AR holding register: ready while empty, captures on valid&ready,
// emptied by the arbiter when the transaction using it is released.
module read_arbiter_ar_req_buf
  import read_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  ar_req_t req_i,
  input  logic    valid_i,
  output logic    ready_o,
  input  logic    clr_i,
  output logic    vld_o,
  output ar_req_t req_o
);

  logic    vld_q, vld_d;
  ar_req_t req_q, req_d;

  // Capture only while empty; release wins, and ready stays low in the release cycle.
  always_comb begin
    vld_d = vld_q;
    req_d = req_q;
    if (clr_i) begin
      vld_d = 1'b0;
    end else if (valid_i && !vld_q) begin
      vld_d = 1'b1;
      req_d = req_i;
    end
  end

  // Entry registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= 1'b0;
      req_q <= '0;
    end else begin
      vld_q <= vld_d;
      req_q <= req_d;
    end
  end

  assign ready_o = ~vld_q;
  assign vld_o   = vld_q;
  assign req_o   = req_q;

endmodule

// File: rtl/read_arbiter.sv
// Round-robin AR arbiter in front of read_fsm: one buffered request per master, one grant
// at a time, grant held from address phase until the granted master's last R beat.
module read_arbiter
  import read_arbiter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  read_arbiter_if.master bus
);

  ar_req_t req_in_0, req_in_1, buf_req_0, buf_req_1, out_req_0, out_req_1;
  logic    buf_vld_0, buf_vld_1, clr_0, clr_1;

  assign req_in_0 = '{id: bus.MREQ_ARID_M0, addr: bus.MREQ_ARADDR_M0, len: bus.MREQ_ARLEN_M0,
                      size: bus.MREQ_ARSIZE_M0, burst: bus.MREQ_ARBURST_M0};
  assign req_in_1 = '{id: bus.MREQ_ARID_M1, addr: bus.MREQ_ARADDR_M1, len: bus.MREQ_ARLEN_M1,
                      size: bus.MREQ_ARSIZE_M1, burst: bus.MREQ_ARBURST_M1};

  read_arbiter_ar_req_buf u_buf_0 (
    .clk(clk), .rst(rst), .req_i(req_in_0), .valid_i(bus.MREQ_ARVALID_M0),
    .ready_o(bus.MREQ_ARREADY_M0), .clr_i(clr_0), .vld_o(buf_vld_0), .req_o(buf_req_0)
  );

  read_arbiter_ar_req_buf u_buf_1 (
    .clk(clk), .rst(rst), .req_i(req_in_1), .valid_i(bus.MREQ_ARVALID_M1),
    .ready_o(bus.MREQ_ARREADY_M1), .clr_i(clr_1), .vld_o(buf_vld_1), .req_o(buf_req_1)
  );

  arb_state_t     state_q, state_d;
  logic           gnt_q, gnt_d;     // granted master, meaningful outside IDLE
  logic           prio_q, prio_d;   // master that wins a tie in IDLE
  logic [LEN_W:0] beat_cnt_q, beat_cnt_d;

  logic             g_arready, g_fire, g_last;
  logic [LEN_W-1:0] g_len;

  assign g_arready = gnt_q ? bus.ARREADY_M1 : bus.ARREADY_M0;
  assign g_fire    = gnt_q ? (bus.RVALID_M1 & bus.RREADY_M1) : (bus.RVALID_M0 & bus.RREADY_M0);
  assign g_last    = gnt_q ? bus.RLAST_M1 : bus.RLAST_M0;
  assign g_len     = gnt_q ? buf_req_1.len : buf_req_0.len;

  // Arbitration FSM: IDLE picks a master, ADDR waits for address accept, DATA counts beats.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    prio_d     = prio_q;
    beat_cnt_d = beat_cnt_q;
    clr_0      = 1'b0;
    clr_1      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (buf_vld_0 && buf_vld_1) begin
          gnt_d   = prio_q;
          state_d = ST_ADDR;
        end else if (buf_vld_0) begin
          gnt_d   = 1'b0;
          state_d = ST_ADDR;
        end else if (buf_vld_1) begin
          gnt_d   = 1'b1;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (g_arready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (g_fire) begin
          // Count-based end guards against a slave that never raises RLAST.
          if (g_last || (beat_cnt_q == {1'b0, g_len})) begin
            state_d    = ST_IDLE;
            beat_cnt_d = '0;
            prio_d     = ~gnt_q;
            clr_0      = ~gnt_q;
            clr_1      = gnt_q;
          end else begin
            beat_cnt_d = beat_cnt_q + (LEN_W+1)'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM, grant, priority and beat counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      prio_q     <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      prio_q     <= prio_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Grant levels and payload muxes are decoded purely from registered state.
  always_comb begin
    bus.ARVALID_M0    = (state_q != ST_IDLE) && !gnt_q;
    bus.ARVALID_M1    = (state_q != ST_IDLE) && gnt_q;
    bus.ARVALID_M0_IN = (state_q == ST_ADDR) && !gnt_q;
    bus.ARVALID_M1_IN = (state_q == ST_ADDR) && gnt_q;
    out_req_0         = bus.ARVALID_M0 ? buf_req_0 : ar_req_idle();
    out_req_1         = bus.ARVALID_M1 ? buf_req_1 : ar_req_idle();
  end

  assign bus.ARID_M0    = out_req_0.id;
  assign bus.ARADDR_M0  = out_req_0.addr;
  assign bus.ARLEN_M0   = out_req_0.len;
  assign bus.ARSIZE_M0  = out_req_0.size;
  assign bus.ARBURST_M0 = out_req_0.burst;
  assign bus.ARID_M1    = out_req_1.id;
  assign bus.ARADDR_M1  = out_req_1.addr;
  assign bus.ARLEN_M1   = out_req_1.len;
  assign bus.ARSIZE_M1  = out_req_1.size;
  assign bus.ARBURST_M1 = out_req_1.burst;

  assign bus.dbg_state    = state_q;
  assign bus.dbg_beat_cnt = beat_cnt_q;

endmodule
